bnn_run_scheduler: RTL and testbench

BNN_RUN_SCHEDULER -- requirements
Module: bnn_run_scheduler

---
 rtl/bnn_pkg.sv | 28 ++
 rtl/bnn_run_scheduler_run_timer.sv | 32 +++
 rtl/bnn_run_scheduler.sv | 148 ++++++++++++++
 tb/tb_bnn_run_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared types and constants for the BNN run scheduler.
// Covers scheduler states, error codes and the image/digit limits.
package bnn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4,
    ST_CLEAR = 3'd5
  } sched_state_t;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_NOT_READY  = 2'd1,
    ERR_TIMEOUT    = 2'd2,
    ERR_BAD_RESULT = 2'd3
  } err_code_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam int         IMG_BYTES = 113;

  function automatic logic is_busy(input sched_state_t s);
    return (s == ST_ARM) || (s == ST_RUN) || (s == ST_CLEAR);
  endfunction

endpackage

// File: rtl/bnn_run_scheduler_run_timer.sv
// Per-attempt RUN timer: counts up while enabled, holds at the terminal
// count instead of wrapping, and flags expiry on the last allowed cycle.
module run_timer
  import bnn_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TC = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != TC)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = enable && (count_q == TC);

endmodule

// File: rtl/bnn_run_scheduler.sv
// Sequences one BNN inference: arm, run with timeout/retry, deliver the digit
// or an error code, and clean up the BNN and image buffer afterwards.
//
// state | meaning
// IDLE  | waiting for start_req
// ARM   | one-cycle BNN clear, timer reset
// RUN   | BNN enabled, waiting for result or timeout
// DONE  | result_data valid until result_ack
// ERROR | err_code reported, waiting for abort/start_req
// CLEAR | one-cycle BNN and image buffer clear
module bnn_run_scheduler
  import bnn_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRIES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_req,
  input  logic       abort,
  input  logic       buffer_full,
  input  logic       bnn_result_ready,
  input  logic [3:0] bnn_result,
  input  logic       result_ack,
  output logic       bnn_enable,
  output logic       bnn_clear,
  output logic       buffer_clear_req,
  output logic       result_valid,
  output logic [3:0] result_data,
  output logic       busy,
  output logic [1:0] err_code,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_out
);

  localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRIES);

  sched_state_t state_q, state_d;
  err_code_t    err_q, err_d;
  logic [1:0]   retry_q, retry_d;
  logic [3:0]   data_q, data_d;
  logic         bnn_clear_d, buf_clr_d;
  logic         timer_clear, timer_enable, timer_expired;

  assign timer_clear  = (state_q != ST_RUN);
  assign timer_enable = (state_q == ST_RUN);

  run_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_run_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    retry_d = retry_q;
    data_d  = data_q;
    // Abort wins over everything else, so no lower-priority side effects leak.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_CLEAR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_req) begin
            if (buffer_full) begin
              state_d = ST_ARM;
              err_d   = ERR_NONE;
              retry_d = 2'd0;
            end else begin
              err_d = ERR_NOT_READY;
            end
          end
        end
        ST_ARM: state_d = ST_RUN;
        ST_RUN: begin
          if (bnn_result_ready) begin
            if (bnn_result <= DIGIT_MAX) begin
              state_d = ST_DONE;
              data_d  = bnn_result;
            end else begin
              state_d = ST_ERROR;
              err_d   = ERR_BAD_RESULT;
            end
          end else if (timer_expired) begin
            if (retry_q < RETRY_LIMIT) begin
              state_d = ST_ARM;
              retry_d = retry_q + 2'd1;
            end else begin
              state_d = ST_ERROR;
              err_d   = ERR_TIMEOUT;
            end
          end else if (!buffer_full) begin
            state_d = ST_ERROR;
            err_d   = ERR_NOT_READY;
          end
        end
        ST_DONE: begin
          if (result_ack) state_d = ST_IDLE;
        end
        ST_ERROR: begin
          if (start_req) state_d = ST_CLEAR;
        end
        ST_CLEAR: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end

    bnn_clear_d = (state_d == ST_ARM) || (state_d == ST_CLEAR);
    // The consumed image is released both on cleanup and on a normal hand-off.
    buf_clr_d   = (state_d == ST_CLEAR) ||
                  ((state_q == ST_DONE) && (state_d == ST_IDLE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      err_q            <= ERR_NONE;
      retry_q          <= 2'd0;
      data_q           <= 4'd0;
      bnn_enable       <= 1'b0;
      bnn_clear        <= 1'b0;
      buffer_clear_req <= 1'b0;
      result_valid     <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state_q          <= state_d;
      err_q            <= err_d;
      retry_q          <= retry_d;
      data_q           <= data_d;
      bnn_enable       <= (state_d == ST_RUN);
      bnn_clear        <= bnn_clear_d;
      buffer_clear_req <= buf_clr_d;
      result_valid     <= (state_d == ST_DONE);
      busy             <= is_busy(state_d);
    end
  end

  assign result_data = data_q;
  assign err_code    = err_q;
  assign retry_cnt   = retry_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_bnn_run_scheduler.sv
// Directed bench for bnn_run_scheduler with hand-computed cycle expectations.
module tb_bnn_run_scheduler;

  localparam int S_IDLE = 0, S_ARM = 1, S_RUN = 2, S_DONE = 3, S_ERROR = 4, S_CLEAR = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_req = 1'b0;
  logic       abort = 1'b0;
  logic       buffer_full = 1'b0;
  logic       bnn_result_ready = 1'b0;
  logic [3:0] bnn_result = 4'd0;
  logic       result_ack = 1'b0;
  logic       bnn_enable, bnn_clear, buffer_clear_req, result_valid, busy;
  logic [3:0] result_data;
  logic [1:0] err_code, retry_cnt;
  logic [2:0] state_out;

  int checks = 0;
  int errors = 0;

  bnn_run_scheduler #(
    .TIMEOUT_CYCLES(16),
    .MAX_RETRIES   (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_req       (start_req),
    .abort           (abort),
    .buffer_full     (buffer_full),
    .bnn_result_ready(bnn_result_ready),
    .bnn_result      (bnn_result),
    .result_ack      (result_ack),
    .bnn_enable      (bnn_enable),
    .bnn_clear       (bnn_clear),
    .buffer_clear_req(buffer_clear_req),
    .result_valid    (result_valid),
    .result_data     (result_data),
    .busy            (busy),
    .err_code        (err_code),
    .retry_cnt       (retry_cnt),
    .state_out       (state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    buffer_full = 1'b1;
    #2;
    check("rst_state", state_out, S_IDLE);
    check("rst_enable", bnn_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_code, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("idle_after_rst", state_out, S_IDLE);

    // abort in IDLE is ignored
    abort = 1'b1; tick(); abort = 1'b0;
    check("idle_abort_state", state_out, S_IDLE);
    check("idle_abort_clear", bnn_clear, 0);

    // nominal run: start at N, result at N+10, ack at N+15
    start_req = 1'b1; tick(); start_req = 1'b0;
    check("arm_clear", bnn_clear, 1);
    check("arm_state", state_out, S_ARM);
    check("arm_enable", bnn_enable, 0);
    check("arm_busy", busy, 1);
    tick();
    check("run_enable_first", bnn_enable, 1);
    check("run_clear_low", bnn_clear, 0);
    check("run_state", state_out, S_RUN);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("run_enable_%0d", i), bnn_enable, 1);
    end
    bnn_result_ready = 1'b1; bnn_result = 4'd7;
    tick();
    bnn_result_ready = 1'b0; bnn_result = 4'd0;
    check("done_valid", result_valid, 1);
    check("done_data", result_data, 7);
    check("done_enable", bnn_enable, 0);
    check("done_state", state_out, S_DONE);
    check("done_busy", busy, 0);
    repeat (4) tick();
    check("done_hold_valid", result_valid, 1);
    check("done_hold_data", result_data, 7);
    result_ack = 1'b1; tick(); result_ack = 1'b0;
    check("ack_bufclr", buffer_clear_req, 1);
    check("ack_state", state_out, S_IDLE);
    check("ack_valid", result_valid, 0);
    tick();
    check("ack_bufclr_pulse", buffer_clear_req, 0);

    // start ignored in RUN, then buffer loss -> not_ready error
    start_req = 1'b1; tick(); start_req = 1'b0;
    tick();
    start_req = 1'b1; tick(); start_req = 1'b0;
    check("run_start_ignored", state_out, S_RUN);
    check("run_start_noclear", bnn_clear, 0);
    buffer_full = 1'b0; tick(); buffer_full = 1'b1;
    check("bufloss_state", state_out, S_ERROR);
    check("bufloss_err", err_code, 1);
    check("bufloss_enable", bnn_enable, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("err_abort_state", state_out, S_CLEAR);
    check("err_abort_clear", bnn_clear, 1);
    check("err_abort_bufclr", buffer_clear_req, 1);
    tick();
    check("clear_to_idle", state_out, S_IDLE);
    check("err_kept_idle", err_code, 1);

    // timeout with retries: three ARM pulses, then ERROR/timeout
    start_req = 1'b1; tick(); start_req = 1'b0;
    for (int a = 0; a < 3; a++) begin
      check($sformatf("to_arm_clear_%0d", a), bnn_clear, 1);
      check($sformatf("to_retry_%0d", a), retry_cnt, a);
      for (int i = 0; i < 16; i++) begin
        tick();
        check($sformatf("to_run_%0d_%0d", a, i), bnn_enable, 1);
      end
      tick();
    end
    check("to_state", state_out, S_ERROR);
    check("to_err", err_code, 2);
    check("to_enable", bnn_enable, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    tick();
    check("to_idle", state_out, S_IDLE);
    check("to_err_kept", err_code, 2);

    // start without a full buffer
    buffer_full = 1'b0;
    start_req = 1'b1; tick(); start_req = 1'b0;
    check("nr_state", state_out, S_IDLE);
    check("nr_err", err_code, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("nr_enable_%0d", i), bnn_enable, 0);
    end
    buffer_full = 1'b1;

    // out-of-range digit
    start_req = 1'b1; tick(); start_req = 1'b0;
    check("bad_retry_reset", retry_cnt, 0);
    tick();
    bnn_result_ready = 1'b1; bnn_result = 4'd12;
    tick();
    bnn_result_ready = 1'b0; bnn_result = 4'd0;
    check("bad_state", state_out, S_ERROR);
    check("bad_err", err_code, 3);
    check("bad_valid", result_valid, 0);
    start_req = 1'b1; tick(); start_req = 1'b0;
    check("bad_clear_state", state_out, S_CLEAR);
    check("bad_clear_pulse", bnn_clear, 1);
    check("bad_bufclr_pulse", buffer_clear_req, 1);
    tick();
    check("bad_idle", state_out, S_IDLE);
    check("bad_clear_low", bnn_clear, 0);
    check("bad_err_kept", err_code, 3);

    // abort beats a same-cycle result
    start_req = 1'b1; tick(); start_req = 1'b0;
    tick();
    abort = 1'b1; bnn_result_ready = 1'b1; bnn_result = 4'd5;
    tick();
    abort = 1'b0; bnn_result_ready = 1'b0; bnn_result = 4'd0;
    check("abrt_state", state_out, S_CLEAR);
    check("abrt_valid", result_valid, 0);
    tick();
    check("abrt_idle", state_out, S_IDLE);
    check("abrt_valid_idle", result_valid, 0);
    check("abrt_data_kept", result_data, 7);

    // asynchronous reset mid-RUN
    start_req = 1'b1; tick(); start_req = 1'b0;
    tick(); tick();
    check("pre_rst_enable", bnn_enable, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_enable", bnn_enable, 0);
    check("arst_state", state_out, S_IDLE);
    check("arst_busy", busy, 0);
    check("arst_data", result_data, 0);
    check("arst_clear", bnn_clear, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_state", state_out, S_IDLE);
    check("post_rst_enable", bnn_enable, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
